// File: rtl/shift_reg_seq_if.sv
// -----------------------------------------------------------------------------
// shift_reg_seq_if
//
// Handshake bundle between a client and the shift_reg_seq sequencer.
//   cmd_valid / cmd_ready / cmd_op   : command channel (0=FILL 1=DRAIN 2=LOAD 3=NOP)
//   in_valid  / in_ready  / in_data  : fill words into the sequencer
//   out_valid / out_ready / out_data : drain words out of the sequencer
//
// master : the client (issues commands, supplies fill words, consumes drains)
// slave  : the sequencer
// -----------------------------------------------------------------------------
interface shift_reg_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;

    modport master (
        output cmd_valid, cmd_op, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_reg_seq.sv
// -----------------------------------------------------------------------------
// shift_reg_seq
//
// Command sequencer for an attached LENGTH-word serial shift register.
// FILL writes LENGTH words from the in_* stream, DRAIN reads LENGTH words out
// on the out_* stream (the shift register rotates, so contents are preserved),
// LOAD pulses a parallel load for one cycle, NOP just completes.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        shift_reg_seq_if.slave : cmd_*, in_*, out_* handshakes
//   ctrl_code  to shift_reg: 0=UPLOAD 1=LOAD 2=WRITE 3=READ
//   data_write to shift_reg: serial write word
//   data_read  from shift_reg: serial read word, valid the cycle after READ
//   busy       high whenever the sequencer is not idle
//   done       one-cycle completion pulse, registered
// -----------------------------------------------------------------------------
module shift_reg_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    shift_reg_seq_if.slave               bus,
    output logic [1:0]                   ctrl_code,
    output logic signed [DATA_WIDTH-1:0] data_write,
    input  logic signed [DATA_WIDTH-1:0] data_read,
    output logic                         busy,
    output logic                         done
);

    localparam int              CNT_W = $clog2(LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_FLUSH,
        S_LOAD
    } state_t;

    typedef enum logic [1:0] {
        CTRL_UPLOAD = 2'd0,
        CTRL_LOAD   = 2'd1,
        CTRL_WRITE  = 2'd2,
        CTRL_READ   = 2'd3
    } ctrl_t;

    localparam logic [1:0] OP_FILL  = 2'd0;
    localparam logic [1:0] OP_DRAIN = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             out_valid_q;
    logic             done_q;

    logic cmd_fire;
    logic read_issue;
    logic out_fire;

    // Handshake qualifiers. A READ is only issued when the output slot is
    // empty or is being emptied this cycle, so data_read never changes under
    // a stalled word.
    assign cmd_fire   = bus.cmd_valid && (state == S_IDLE);
    assign read_issue = (state == S_DRAIN) && (!out_valid_q || bus.out_ready);
    assign out_fire   = ((state == S_DRAIN) || (state == S_FLUSH))
                        && out_valid_q && bus.out_ready;

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.in_ready  = (state == S_FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_read;
    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign data_write    = (state == S_FILL) ? bus.in_data : '0;

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl_code = CTRL_UPLOAD;
        unique case (state)
            S_FILL:  if (bus.in_valid) ctrl_code = CTRL_WRITE;
            S_DRAIN: if (read_issue)   ctrl_code = CTRL_READ;
            S_LOAD:  ctrl_code = CTRL_LOAD;
            default: ctrl_code = CTRL_UPLOAD;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of statement
    // order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    count <= '0;
                    if (cmd_fire) begin
                        unique case (bus.cmd_op)
                            OP_FILL:  state  <= S_FILL;
                            OP_DRAIN: state  <= S_DRAIN;
                            OP_LOAD:  state  <= S_LOAD;
                            default:  done_q <= 1'b1;   // NOP completes at once
                        endcase
                    end
                end

                S_FILL: begin
                    // Only real handshakes count; idle input cycles are UPLOADs.
                    if (bus.in_valid) begin
                        if (count == LAST) begin
                            count  <= '0;
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (read_issue) begin
                        // A READ refills the slot even if it is consumed now.
                        out_valid_q <= 1'b1;
                        if (count == LAST) begin
                            count <= '0;
                            state <= S_FLUSH;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end

                S_FLUSH: begin
                    // Last word is in the slot; wait for it to be taken.
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                        done_q      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_seq
//
// Bench for shift_reg_seq (DATA_WIDTH=8, LENGTH=4). Includes a behavioural
// model of the attached shift register: WRITE shifts toward index 0 with the
// new word entering at the top, READ registers contents[0] onto data_read and
// rotates, LOAD parallel-loads A0,A1,A2,A3.
// Expected write words and drain words are queued when stimulus is driven and
// compared by a negedge monitor when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_shift_reg_seq;

    localparam int DW  = 8;
    localparam int LEN = 4;

    logic                 clk;
    logic                 reset_n;
    logic [1:0]           ctrl_code;
    logic signed [DW-1:0] data_write;
    logic signed [DW-1:0] data_read;
    logic                 busy;
    logic                 done;

    shift_reg_seq_if #(.DATA_WIDTH(DW)) bus ();

    shift_reg_seq #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .ctrl_code  (ctrl_code),
        .data_write (data_write),
        .data_read  (data_read),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shift register model ----------------
    logic [DW-1:0] sr [LEN];

    always @(posedge clk) begin
        case (ctrl_code)
            2'd1: begin
                sr[0] <= 8'hA0; sr[1] <= 8'hA1; sr[2] <= 8'hA2; sr[3] <= 8'hA3;
            end
            2'd2: begin
                for (int i = 0; i < LEN - 1; i++) sr[i] <= sr[i+1];
                sr[LEN-1] <= data_write;
            end
            2'd3: begin
                for (int i = 0; i < LEN - 1; i++) sr[i] <= sr[i+1];
                sr[LEN-1] <= sr[0];
            end
            default: ;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)             data_read <= '0;
        else if (ctrl_code == 2'd3) data_read <= sr[0];
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [DW-1:0] wr_q [$];
    logic [DW-1:0] rd_q [$];
    logic          prev_done = 1'b0;
    logic [DW-1:0] mon_e;

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done = 1'b0;
        end else begin
            if (ctrl_code == 2'd2) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1'b0, 32'(data_write), 32'hx);
                end else begin
                    mon_e = wr_q.pop_front();
                    check("data_write", data_write == mon_e, 32'(data_write), 32'(mon_e));
                end
            end
            if (ctrl_code == 2'd3) rd_cnt++;
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_no_read", ctrl_code != 2'd3, 32'(ctrl_code), 32'd0);
                if (rd_q.size() > 0)
                    check("stall_hold", bus.out_data == rd_q[0], 32'(bus.out_data), 32'(rd_q[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_out", 1'b0, 32'(bus.out_data), 32'hx);
                end else begin
                    mon_e = rd_q.pop_front();
                    check("out_data", bus.out_data == mon_e, 32'(bus.out_data), 32'(mon_e));
                end
            end
            if (done && prev_done) check("done_single", 1'b0, 32'd1, 32'd0);
            prev_done = done;
        end
    end

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic send_cmd(input logic [1:0] op);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", bus.cmd_ready, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd3;
    endtask

    task automatic fill(input logic [DW-1:0] w [LEN], input int gap);
        int wr0 = wr_cnt;
        int n;
        for (int i = 0; i < LEN; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("fill_gap", ctrl_code == 2'd0 && busy && bus.in_ready,
                          {28'd0, ctrl_code, busy, bus.in_ready}, 32'b0011);
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            wr_q.push_back(w[i]);
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("fill_ready", bus.in_ready, 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("fill_done", done && !busy, {30'd0, done, busy}, 32'b10);
        check("fill_writes", wr_cnt - wr0 == LEN, 32'(wr_cnt - wr0), 32'(LEN));
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_done_pulse", !done, 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int stall, input logic [DW-1:0] exp [LEN]);
        int got = 0, cyc = 0, first = 0, last = 0, n = 0;
        int rd0 = rd_cnt;
        for (int i = 0; i < LEN; i++) rd_q.push_back(exp[i]);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("drain_first_valid", bus.out_valid, 32'(bus.out_valid), 32'd1);
            repeat (stall - 1) @(posedge clk);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        while (got < LEN && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
                got++;
                if (got == 1) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        check("drain_words", got == LEN, 32'(got), 32'(LEN));
        check("drain_rate", last - first == LEN - 1, 32'(last - first), 32'(LEN - 1));
        check("drain_reads", rd_cnt - rd0 == LEN, 32'(rd_cnt - rd0), 32'(LEN));
        @(negedge clk);
        check("drain_done", done && !busy, {30'd0, done, busy}, 32'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_done_pulse", !done, 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] fill_w [LEN];
        int            gap;
        int            stall;
        int            drains;
        logic [DW-1:0] exp_w  [LEN];
    } vec_t;

    vec_t vecs [5];

    task automatic run_row(input int r);
        send_cmd(2'd0);
        fill(vecs[r].fill_w, vecs[r].gap);
        for (int d = 0; d < vecs[r].drains; d++) begin
            send_cmd(2'd1);
            drain(vecs[r].stall, vecs[r].exp_w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] load_exp [LEN];

        vecs[0].fill_w = '{8'h11, 8'h22, 8'h33, 8'h44}; vecs[0].gap = 0; vecs[0].stall = 0;
        vecs[0].drains = 1; vecs[0].exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1].fill_w = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[1].gap = 2; vecs[1].stall = 0;
        vecs[1].drains = 1; vecs[1].exp_w = '{8'h01, 8'h02, 8'h03, 8'h04};
        vecs[2].fill_w = '{8'h11, 8'h22, 8'h33, 8'h44}; vecs[2].gap = 0; vecs[2].stall = 3;
        vecs[2].drains = 2; vecs[2].exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        vecs[3].fill_w = '{8'h80, 8'hFF, 8'h7F, 8'h00}; vecs[3].gap = 0; vecs[3].stall = 0;
        vecs[3].drains = 1; vecs[3].exp_w = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        vecs[4].fill_w = '{8'h5A, 8'hA5, 8'h01, 8'hFE}; vecs[4].gap = 1; vecs[4].stall = 1;
        vecs[4].drains = 2; vecs[4].exp_w = '{8'h5A, 8'hA5, 8'h01, 8'hFE};
        load_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd3;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_state", !bus.out_valid && !bus.in_ready && !busy && !done
                           && ctrl_code == 2'd0 && bus.cmd_ready && data_write == '0,
              {25'd0, bus.out_valid, bus.in_ready, busy, done, ctrl_code, bus.cmd_ready},
              32'b0000001);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 5; r++) run_row(r);

        // LOAD: one cycle of ctrl_code=1, then done; drain returns loaded pattern
        send_cmd(2'd2);
        @(negedge clk);
        check("load_ctrl", ctrl_code == 2'd1 && busy, {29'd0, ctrl_code, busy}, 32'b011);
        @(posedge clk); #1;
        @(negedge clk);
        check("load_done", done && ctrl_code == 2'd0 && bus.cmd_ready,
              {28'd0, done, ctrl_code, bus.cmd_ready}, 32'b1001);
        @(posedge clk); #1;
        send_cmd(2'd1);
        drain(0, load_exp);

        // Reset mid-FILL after two handshakes: no done, then NOP completes
        send_cmd(2'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'h11; wr_q.push_back(8'h11);
        @(negedge clk); @(posedge clk); #1;
        bus.in_data = 8'h22; wr_q.push_back(8'h22);
        @(negedge clk); @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_fill", !busy && bus.cmd_ready && !bus.in_ready && ctrl_code == 2'd0
                          && data_write == '0,
              {27'd0, busy, bus.cmd_ready, bus.in_ready, ctrl_code}, 32'b01000);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        check("rst_fill_no_done", !done && !busy, {30'd0, done, busy}, 32'd0);
        check("rst_fill_queue", wr_q.size() == 0, 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;
        send_cmd(2'd3);
        @(negedge clk);
        check("nop_done", done && ctrl_code == 2'd0, {29'd0, done, ctrl_code}, 32'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("nop_done_pulse", !done && ctrl_code == 2'd0, {29'd0, done, ctrl_code}, 32'b000);
        @(posedge clk); #1;

        // Reset mid-cycle while a drain word is stalled in the output slot
        run_row(0);
        send_cmd(2'd1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_read", ctrl_code == 2'd3, 32'(ctrl_code), 32'd3);
        @(posedge clk); #3;
        check("pre_rst_valid", bus.out_valid, 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid", !bus.out_valid && !bus.in_ready && !busy && ctrl_code == 2'd0
                         && bus.cmd_ready,
              {27'd0, bus.out_valid, bus.in_ready, busy, ctrl_code[0], bus.cmd_ready},
              32'b00001);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Normal operation resumes after reset
        run_row(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of all data paths (signed).
REQ-002 SHALL have parameter LENGTH, default 4, number of words per FILL/DRAIN (equals the LENGTH of the attached shift_reg).
REQ-003 SHALL have ports, clock and reset first, one clock domain; reset_n is asynchronous, active-low:
  clk  input  1  rising-edge clock
  reset_n  input  1  asynchronous active-low reset
  cmd_valid  input  1  command offered
  cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
  cmd_op  input  2  0=FILL, 1=DRAIN, 2=LOAD, 3=NOP
  in_valid  input  1  fill word offered
  in_ready  output  1  fill word accepted when in_valid && in_ready
  in_data  input  DATA_WIDTH  signed fill word
  out_valid  output  1  drain word available
  out_ready  input  1  drain word consumed when out_valid && out_ready
  out_data  output  DATA_WIDTH  signed drain word
  ctrl_code  output  2  to shift_reg: 0=UPLOAD, 1=LOAD, 2=WRITE, 3=READ
  data_write  output  DATA_WIDTH  to shift_reg serial write word
  data_read  input  DATA_WIDTH  from shift_reg serial read word (registered there, valid cycle after READ)
  busy  output  1  high whenever state != IDLE
  done  output  1  one-cycle completion pulse

Function
REQ-004 SHALL implement FSM states IDLE, FILL, DRAIN, FLUSH, LOAD; cmd_ready = (state==IDLE).
REQ-005 SHALL, in IDLE on cmd accept, go FILL (op 0), DRAIN (op 1), LOAD (op 2), or stay IDLE with done next cycle (op 3).
REQ-006 SHALL drive ctrl_code=0 (UPLOAD, non-destructive) in every cycle not otherwise specified.
REQ-007 SHALL, in FILL, drive in_ready=1, data_write=in_data combinationally, ctrl_code=2 only in cycles with in_valid=1; cycles with in_valid=0 issue UPLOAD and do not count.
REQ-008 SHALL count FILL handshakes with counter of width $clog2(LENGTH+1); after the LENGTH-th handshake go IDLE with done=1 the following cycle; in_ready=0 outside FILL.
REQ-009 SHALL, in DRAIN, drive ctrl_code=3 in a cycle iff (!out_valid || out_ready), counting each READ issued.
REQ-010 SHALL set out_valid=1 the cycle after each READ; clear it after out_valid && out_ready with no READ in the same cycle.
REQ-011 SHALL drive out_data = data_read combinationally; data_read is stable while out_valid && !out_ready since no READ is issued.
REQ-012 SHALL, after the LENGTH-th READ, go FLUSH; in FLUSH issue no READ; on out_valid && out_ready go IDLE with done=1 next cycle.
REQ-013 SHALL deliver exactly LENGTH drain words in shift order (contents[0] first); rotation restores shift_reg contents, so a repeated DRAIN returns the same sequence.
REQ-014 SHALL, in LOAD, drive ctrl_code=1 for exactly one cycle, then IDLE with done=1 next cycle.
REQ-015 SHALL register done; done is never high for more than one consecutive cycle per command; a new command may be accepted in the done cycle.
REQ-016 SHALL pass data unmodified (no sign extension or truncation); all words are DATA_WIDTH bits.
REQ-017 SHALL ignore in_valid outside FILL and out_ready outside DRAIN/FLUSH.

Reset
REQ-018 SHALL, on reset_n=0, asynchronously force state=IDLE, counter=0, out_valid=0, done=0, busy=0, cmd_ready=1, in_ready=0, ctrl_code=0, data_write=0.
REQ-019 SHALL discard any in-progress command on reset mid-operation with no done pulse; resume normal operation the first clk edge after reset_n=1.

Verification (LENGTH=4, DATA_WIDTH=8)
REQ-020 Reset: reset_n=0 mid-cycle -> same-cycle out_valid=0, in_ready=0, busy=0, ctrl_code=0, cmd_ready=1.
REQ-021 FILL 0x11,0x22,0x33,0x44 back-to-back -> ctrl_code=2 four cycles, data_write in order, done one cycle after 4th handshake; then DRAIN with out_ready=1 -> out_data 0x11,0x22,0x33,0x44, one word per cycle.
REQ-022 FILL with in_valid low 2 cycles between words -> ctrl_code=0 in gap cycles, exactly four WRITEs, busy held throughout.
REQ-023 DRAIN with out_ready low 3 cycles after first word -> out_data held 0x11, no READ issued during stall; all four words in order; second DRAIN returns same four words.
REQ-024 FILL 0x80,0xFF,0x7F,0x00 then DRAIN -> identical bit patterns out (signed extremes preserved).
REQ-025 Reset asserted after 2 FILL handshakes -> immediate IDLE, no done; subsequent cmd_op=3 -> done=1 exactly one cycle, ctrl_code stays 0.
